// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage fetch controller.
//
// Holds the fetch PC and picks the next PC from one of three sources: the ID-stage
// redirect, the branch target buffer prediction, or the sequential PC+4. The BTB
// prediction made for each fetched instruction (hit flag and predicted next PC) is
// carried through the IF/ID register so ID can resolve it against the real branch
// outcome. Resolved branches and mispredictions are counted in saturating counters.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   stall_IF                  hold the PC register
//   stall_ID                  hold the IF/ID register; ID outcome not final while high
//   flush_ID                  inject a bubble into IF/ID
//   imem_inst                 instruction fetched at PC_IF (same cycle)
//   btb_hit, btb_pred_PC      BTB lookup result for PC_IF
//   is_Branch_ID, Branch_ID,  ID-stage branch/jump flag, taken flag and resolved target
//   Branch_Addr
//   PC_IF                     current fetch PC
//   PC_ID, inst_ID, valid_ID  IF/ID register contents
//   hit_ID, pred_PC_ID        prediction metadata for the ID instruction
//   mispredict, redirect_PC   combinational misprediction flag and corrected next PC
//   branch_cnt, mispred_cnt   saturating performance counters

module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_IF,
  input  logic             stall_ID,
  input  logic             flush_ID,
  input  logic [31:0]      imem_inst,
  input  logic             btb_hit,
  input  logic [31:0]      btb_pred_PC,
  input  logic             is_Branch_ID,
  input  logic             Branch_ID,
  input  logic [31:0]      Branch_Addr,
  output logic [31:0]      PC_IF,
  output logic [31:0]      PC_ID,
  output logic [31:0]      inst_ID,
  output logic             valid_ID,
  output logic             hit_ID,
  output logic [31:0]      pred_PC_ID,
  output logic             mispredict,
  output logic [31:0]      redirect_PC,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  // State
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc_id_q, pc_id_d;
  logic [31:0]      inst_id_q, inst_id_d;
  logic             valid_id_q, valid_id_d;
  logic             hit_id_q, hit_id_d;
  logic [31:0]      pred_pc_id_q, pred_pc_id_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  // ID-stage resolution
  logic        resolve;
  logic        taken;
  logic        pred_taken_wrong;
  logic        wrong_target;
  logic        missed_taken;
  logic        mispredict_w;
  logic [31:0] redirect_w;
  logic [31:0] pc_seq;
  logic [31:0] pc_id_seq;

  always_comb begin
    pc_seq           = pc_q + 32'd4;
    pc_id_seq        = pc_id_q + 32'd4;
    // Outcome is only final once ID is no longer stalled.
    resolve          = valid_id_q && !stall_ID;
    taken            = is_Branch_ID && Branch_ID;
    pred_taken_wrong = hit_id_q && !taken;
    wrong_target     = hit_id_q && taken && (Branch_Addr != pred_pc_id_q);
    missed_taken     = !hit_id_q && taken;
    mispredict_w     = resolve && (pred_taken_wrong || wrong_target || missed_taken);
    // Only the target-related cases fetch from Branch_Addr; everything else falls
    // through to the instruction after the one in ID.
    redirect_w       = (wrong_target || missed_taken) ? Branch_Addr : pc_id_seq;
  end

  // Next fetch PC: redirect beats stall beats prediction beats sequential.
  always_comb begin
    pc_d = pc_seq;
    if (mispredict_w) begin
      pc_d = redirect_w;
    end else if (stall_IF) begin
      pc_d = pc_q;
    end else if (btb_hit) begin
      pc_d = btb_pred_PC;
    end
  end

  // IF/ID register next state.
  always_comb begin
    pc_id_d      = pc_id_q;
    inst_id_d    = inst_id_q;
    valid_id_d   = valid_id_q;
    hit_id_d     = hit_id_q;
    pred_pc_id_d = pred_pc_id_q;
    if (mispredict_w || flush_ID) begin
      // Squash the wrong-path (or flushed) fetch; flush overrides stall_ID.
      pc_id_d      = pc_q;
      inst_id_d    = Nop;
      valid_id_d   = 1'b0;
      hit_id_d     = 1'b0;
      pred_pc_id_d = 32'h0;
    end else if (stall_ID) begin
      // Hold all fields.
    end else if (stall_IF) begin
      // The PC is held, so the same fetch reappears next cycle; pass a bubble now
      // to avoid issuing it twice.
      pc_id_d      = pc_q;
      inst_id_d    = Nop;
      valid_id_d   = 1'b0;
      hit_id_d     = 1'b0;
      pred_pc_id_d = 32'h0;
    end else begin
      pc_id_d      = pc_q;
      inst_id_d    = imem_inst;
      valid_id_d   = 1'b1;
      hit_id_d     = btb_hit;
      pred_pc_id_d = btb_hit ? btb_pred_PC : pc_seq;
    end
  end

  // Saturating performance counters.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resolve && is_Branch_ID && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (mispredict_w && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      pc_id_q       <= 32'h0;
      inst_id_q     <= Nop;
      valid_id_q    <= 1'b0;
      hit_id_q      <= 1'b0;
      pred_pc_id_q  <= 32'h0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      pc_q          <= pc_d;
      pc_id_q       <= pc_id_d;
      inst_id_q     <= inst_id_d;
      valid_id_q    <= valid_id_d;
      hit_id_q      <= hit_id_d;
      pred_pc_id_q  <= pred_pc_id_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign PC_IF       = pc_q;
  assign PC_ID       = pc_id_q;
  assign inst_ID     = inst_id_q;
  assign valid_ID    = valid_id_q;
  assign hit_ID      = hit_id_q;
  assign pred_PC_ID  = pred_pc_id_q;
  assign mispredict  = mispredict_w;
  assign redirect_PC = redirect_w;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule
